// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit combinational full adder, time-shared by the serial controller.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds a + b + ci over WIDTH cycles using one fa_cell.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int unsigned CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              carry_q, carry_d;
    logic              co_q, co_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              fs, fc;

    fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fs),
        .co (fc)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // LSB-first: each new sum bit enters at the MSB so bit 0 ends up first.
                sum_d   = {fs, sum_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fc;
                if (cnt_q == CNT_LAST) begin
                    s_d     = sum_d;
                    co_d    = fc;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, ci8, busy8, done8, co8;
    logic [7:0] a8, b8, s8;
    logic       start2, ci2, busy2, done2, co2;
    logic [1:0] a2, b2, s2;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .ci(ci2),
        .busy(busy2), .done(done2), .s(s2), .co(co2)
    );

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned done_cnt8 = 0;
    logic [8:0] exp8_q[$];
    logic [2:0] exp2_q[$];
    logic [8:0] e8;
    logic [2:0] e2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            if (exp8_q.size() == 0) begin
                check("w8 unexpected done", 64'd1, 64'd0);
            end else begin
                e8 = exp8_q.pop_front();
                check("w8 sum", {55'd0, co8, s8}, {55'd0, e8});
            end
        end
        if (done2) begin
            if (exp2_q.size() == 0) begin
                check("w2 unexpected done", 64'd1, 64'd0);
            end else begin
                e2 = exp2_q.pop_front();
                check("w2 sum", {61'd0, co2, s2}, {61'd0, e2});
            end
        end
    end

    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int unsigned r;
        r = int'(x) + int'(y) + int'(c);
        return 9'(r);
    endfunction

    task automatic wait_idle8();
        for (int i = 0; i < 40; i++) begin
            if (!busy8) return;
            @(negedge clk);
        end
        check("w8 idle timeout", 64'd0, 64'd1);
    endtask

    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic c,
                          input bit push);
        wait_idle8();
        a8 = x; b8 = y; ci8 = c; start8 = 1'b1;
        if (push) exp8_q.push_back(ref8(x, y, c));
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("w8 done timeout", 64'd0, 64'd1);
    endtask

    task automatic op2(input logic [1:0] x, input logic [1:0] y, input logic c);
        int unsigned r;
        for (int i = 0; i < 20 && busy2; i++) @(negedge clk);
        r = int'(x) + int'(y) + int'(c);
        a2 = x; b2 = y; ci2 = c; start2 = 1'b1;
        exp2_q.push_back(3'(r));
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done2) return;
        end
        check("w2 done timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, nbusy, ndone, dc;
        logic [7:0] ra, rb;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", {63'd0, busy8}, 64'd0);
        check("reset done", {63'd0, done8}, 64'd0);
        check("reset s", {56'd0, s8}, 64'd0);
        check("reset co", {63'd0, co8}, 64'd0);
        check("reset w2 sum", {61'd0, co2, s2}, 64'd0);
        repeat (3) @(negedge clk);
        check("idle stays quiet", {62'd0, busy8, done8}, 64'd0);

        // Zero operands, done latency
        issue8(8'h00, 8'h00, 1'b0, 1'b1);
        wait_done8(lat);
        check("done latency", 64'(lat), 64'd9);

        // Carry out, busy/done widths
        issue8(8'hFF, 8'h01, 1'b0, 1'b1);
        nbusy = 0; ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (busy8) nbusy++;
            if (done8) ndone++;
        end
        check("busy width", 64'(nbusy), 64'd9);
        check("done width", 64'(ndone), 64'd1);

        // Start held high across done
        wait_idle8();
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; start8 = 1'b1;
        exp8_q.push_back(ref8(8'hFF, 8'hFF, 1'b1));
        exp8_q.push_back(ref8(8'hFF, 8'hFF, 1'b1));
        @(posedge clk);
        #1;
        wait_done8(lat);
        @(negedge clk);
        check("start ignored in done", {63'd0, busy8}, 64'd0);
        @(negedge clk);
        check("start accepted after done", {63'd0, busy8}, 64'd1);
        start8 = 1'b0;
        wait_done8(lat);
        check("held-start latency", 64'(lat), 64'd8);

        // Starts during run/done and operand changes are ignored
        issue8(8'h5A, 8'h3C, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            start8 = (k == 3 || k == 9);
            b8 = 8'h00;
            @(negedge clk);
            if (k == 2) check("result held in run", {55'd0, co8, s8}, 64'h1FF);
            @(posedge clk);
            #1;
        end
        start8 = 1'b0;
        @(negedge clk);
        check("no requeue 1", {63'd0, busy8}, 64'd0);
        @(negedge clk);
        check("no requeue 2", {63'd0, busy8}, 64'd0);

        // Reset mid-run aborts
        dc = int'(done_cnt8);
        issue8(8'h80, 8'h80, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort busy", {63'd0, busy8}, 64'd0);
        check("abort result", {55'd0, co8, s8}, 64'd0);
        repeat (12) @(negedge clk);
        check("abort no done", 64'(done_cnt8), 64'(dc));
        issue8(8'h80, 8'h80, 1'b0, 1'b1);
        wait_done8(lat);
        check("post-abort latency", 64'(lat), 64'd9);

        // Random sweep
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            issue8(ra, rb, 1'($urandom), 1'b1);
            wait_done8(lat);
        end

        // Exhaustive WIDTH=2
        for (int n = 0; n < 32; n++) begin
            op2(2'(n & 3), 2'((n >> 2) & 3), 1'((n >> 4) & 1));
        end

        repeat (3) @(negedge clk);
        check("w8 queue drained", 64'(exp8_q.size()), 64'd0);
        check("w2 queue drained", 64'(exp2_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
